// File: rtl/text_line_sprites.sv
// text_line_sprites: 4-stage text-line sprite renderer over an external 1-cycle font ROM.
// Define TEXT_BLINK_EN to add blink_in and a 64-frame blink counter.
module text_line_sprites #(
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 8,
  parameter int SHEET_W    = 143,
  parameter int SHEET_COLS = 16,
  parameter int MAX_CHARS  = 16
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic [10:0]                  x_in,
  input  logic [9:0]                   y_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         scale_in,
  input  logic [11:0]                  color_in,
  input  logic                         wr_valid_in,
  input  logic [$clog2(MAX_CHARS)-1:0] wr_idx_in,
  input  logic [7:0]                   wr_char_in,
  output logic                         wr_ready_out,
  input  logic [$clog2(MAX_CHARS):0]   len_in,
  output logic [15:0]                  rom_addr_out,
  input  logic [7:0]                   rom_data_in,
`ifdef TEXT_BLINK_EN
  input  logic                         blink_in,
`endif
  output logic [11:0]                  pixel_out
);
  localparam int IW  = $clog2(MAX_CHARS);
  localparam int GXW = $clog2(GLYPH_W);
  localparam int GYW = $clog2(GLYPH_H);
  logic [7:0]     buf_q [MAX_CHARS];
  logic [IW:0]    len_q, len_d;
  logic [11:0]    dx, dy, cw, ch;
  logic [15:0]    box_w;
  logic           in_box, band, we, lit;
  logic           v1_q, v2_q, v3_q, v2_d;
  logic [IW-1:0]  slot_q, slot_d;
  logic [GXW-1:0] gx_q, gx_d;
  logic [GYW-1:0] gy_q, gy_d;
  logic [7:0]     chr;
  logic [15:0]    addr_q, addr_d;
  logic [11:0]    color_q, pix_q, pix_d;
  // dx/dy carry a sign bit so positions left of or above the box never wrap inside
  always_comb begin
    dx     = {1'b0, hcount_in} - {1'b0, x_in};
    dy     = {2'b0, vcount_in} - {2'b0, y_in};
    cw     = scale_in ? 12'(2 * GLYPH_W) : 12'(GLYPH_W);
    ch     = scale_in ? 12'(2 * GLYPH_H) : 12'(GLYPH_H);
    box_w  = 16'(len_q) * {4'b0, cw};
    in_box = !dx[11] && !dy[11] && ({4'b0, dx} < box_w) && (dy < ch);
    slot_d = IW'(dx / cw);
    gx_d   = GXW'((dx % cw) >> scale_in);
    gy_d   = GYW'(dy >> scale_in);
    band   = !dy[11] && (dy < 12'(2 * GLYPH_H));
    we     = wr_valid_in && !band && !rst_in;
    len_d  = (len_in > (IW+1)'(MAX_CHARS)) ? (IW+1)'(MAX_CHARS) : len_in;
    chr    = buf_q[slot_q];
    v2_d   = v1_q && (chr != 8'h20);
    addr_d = 16'((32'(chr) / SHEET_COLS * GLYPH_H + 32'(gy_q)) * SHEET_W
                 + 32'(chr) % SHEET_COLS * GLYPH_W + 32'(gx_q));
  end
  assign wr_ready_out = !band;
`ifdef TEXT_BLINK_EN
  logic [5:0] frame_q;
  always_ff @(posedge pixel_clk_in)
    if (rst_in) frame_q <= 6'd0;
    else if (hcount_in == 11'd0 && vcount_in == 10'd0) frame_q <= frame_q + 6'd1;
  assign lit = v3_q && (rom_data_in >= 8'h80) && !(blink_in && frame_q[5]);
`else
  assign lit = v3_q && (rom_data_in >= 8'h80);
`endif
  assign pix_d = lit ? color_q : 12'h000;
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      len_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      addr_q <= 16'd0;
      pix_q  <= 12'h000;
    end else begin
      if (we) len_q <= len_d;
      v1_q   <= in_box;
      v2_q   <= v2_d;
      v3_q   <= v2_q;
      addr_q <= addr_d;
      pix_q  <= pix_d;
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    slot_q  <= slot_d;
    gx_q    <= gx_d;
    gy_q    <= gy_d;
    color_q <= color_in;
  end
  // indices with no matching entry simply write nothing
  always_ff @(posedge pixel_clk_in)
    for (int i = 0; i < MAX_CHARS; i++)
      if (rst_in) buf_q[i] <= 8'h20;
      else if (we && wr_idx_in == IW'(i)) buf_q[i] <= wr_char_in;
  assign rom_addr_out = addr_q;
  assign pixel_out    = pix_q;
endmodule
